audio_i2s_bridge: RTL and testbench
===================================

Name: audio_i2s_bridge

Overview:
Sample-level I/O peer of the audio CPU. It accepts filtered samples from the CPU (outport/output_valid), buffers them in a small FIFO and serialises them to the DAC as I2S. It deserialises ADC I2S data into a holding register presented on adcdata, which the CPU consumes via input_ready. The block is the bus master for the I2S clocks.

Parameters:
DWIDTH, 32, sample width and I2S slot width in bits
BCLKDIV, 2, system clocks per bclk half-period (>=1)
FIFODEPTH, 4, TX sample FIFO entries (power of 2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
outport  in  DWIDTH  sample from CPU
output_valid  in  1  CPU sample strobe; one FIFO write per high cycle
input_ready  in  1  CPU consume strobe for adcdata
adcdata  out  DWIDTH  latest received ADC sample (left slot)
adc_valid  out  1  adcdata holds an unconsumed sample
tx_overflow  out  1  sticky: a write was dropped because the FIFO was full
rx_overrun  out  1  sticky: an unconsumed sample was overwritten
bclk  out  1  I2S bit clock
lrclk  out  1  I2S word select; 0 = left, 1 = right
dac_sdata  out  1  I2S serial data to DAC
adc_sdata  in  1  I2S serial data from ADC

Behaviour:
- Reset (reset=0, asynchronous): bclk=0, lrclk=0, dac_sdata=0, adcdata=0, adc_valid=0, tx_overflow=0, rx_overrun=0. Divider=0, bit index b=0, FIFO empty, TX word register=0. Applies immediately, including mid-frame.
- Clock gen: divider counts 0..BCLKDIV-1 and toggles bclk on wrap. The first bclk rise is BCLKDIV clocks after reset release.
- Bit index b is 0..2*DWIDTH-1. It increments on every bclk falling edge and wraps to 0. lrclk = (b >= DWIDTH), updated on the same falling edge.
- I2S format: 1-bit delay after the lrclk edge, MSB first.
  - Slot bits occupy b=1..DWIDTH (left) and b=DWIDTH+1..2*DWIDTH-1, then b=0 of the next frame (right).
  - dac_sdata changes only on bclk falling edges.
- TX:
  - On the falling edge entering b=1, pop the FIFO head into the TX word register if the FIFO is non-empty; otherwise keep the previous word (repeat last sample).
  - Left slot transmits the word MSB to LSB. Right slot transmits the same word again (mono duplicated).
  - The LSB of the right slot is driven during b=0 of the following frame.
- FIFO write: output_valid=1 with the FIFO not full writes outport. Write while full: data dropped, tx_overflow<=1.
- Simultaneous write and pop when full: the pop frees a slot, so the write is accepted with no overflow.
- RX:
  - Sample adc_sdata on bclk rising edges during b=1..DWIDTH into a shift register, MSB first. Right-slot data is ignored.
  - On the rising edge at b=DWIDTH, the completed word is written to adcdata on the next clock and adc_valid<=1.
  - If adc_valid was already 1 and input_ready is not asserted that same clock, rx_overrun<=1 and adcdata is overwritten.
- Consume: input_ready=1 while adc_valid=1 clears adc_valid next clock; adcdata is unchanged. input_ready while adc_valid=0 has no effect.
- Completion and consume in the same clock: new word loaded, adc_valid stays 1, no overrun.
- Sticky flags clear only on reset.
- Frame length is 4*BCLKDIV*DWIDTH clocks (256 at defaults).

Test Plan:
1. Reset held, then released -> all outputs 0. bclk toggles every 2 clocks. lrclk low for 32 bclk periods, high for 32. Frame = 256 clocks.
2. Single output_valid pulse with outport=0xA5A50001, FIFO empty -> dac_sdata in left slot (b=1..32) = 1010_0101_1010_0101_0000_0000_0000_0001. Right slot identical. Later frames repeat the same word.
3. Five back-to-back output_valid cycles with 0x1..0x5 and no frame boundary in between -> 0x1..0x4 stored, 0x5 dropped, tx_overflow=1. Subsequent frames send 1, 2, 3, 4, 4, 4...
4. ADC model drives left=0x80000003, right=0xFFFFFFFF -> adcdata=0x80000003 and adc_valid=1 after left slot completes. One-clock input_ready -> adc_valid=0 next clock; adcdata still 0x80000003.
5. Two frames with left=0x11111111 then 0x22222222 and no input_ready -> rx_overrun=1, adcdata=0x22222222. Repeat with input_ready coinciding with the second completion -> rx_overrun stays 0.
6. Assert reset at b=17 with FIFO holding 2 entries and adc_valid=1 -> all outputs 0 in the same cycle, FIFO empty. After release, a fresh frame starts at b=0.

Source files
------------

// File: rtl/audio_i2s_bridge.sv
// I2S master bridging the audio CPU sample interface to a DAC (TX, mono duplicated)
// and an ADC (RX, left slot only), with a small TX FIFO and an RX holding register.
module audio_i2s_bridge #(
  parameter int DWIDTH    = 32,
  parameter int BCLKDIV   = 2,
  parameter int FIFODEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DWIDTH-1:0] outport,
  input  logic              output_valid,
  input  logic              input_ready,
  output logic [DWIDTH-1:0] adcdata,
  output logic              adc_valid,
  output logic              tx_overflow,
  output logic              rx_overrun,
  output logic              bclk,
  output logic              lrclk,
  output logic              dac_sdata,
  input  logic              adc_sdata
);

  localparam int BW   = $clog2(2 * DWIDTH);
  localparam int DIVW = (BCLKDIV > 1) ? $clog2(BCLKDIV) : 1;
  localparam int AW   = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
  localparam int CW   = $clog2(FIFODEPTH + 1);

  localparam logic [BW-1:0]   B_ONE    = BW'(1);
  localparam logic [BW-1:0]   B_DW     = BW'(DWIDTH);
  localparam logic [BW-1:0]   B_RSTART = BW'(DWIDTH + 1);
  localparam logic [BW-1:0]   B_LAST   = BW'(2 * DWIDTH - 1);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BCLKDIV - 1);
  localparam logic [AW-1:0]   PTR_LAST = AW'(FIFODEPTH - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(FIFODEPTH);

  logic [DIVW-1:0]   div_q;
  logic [BW-1:0]     b_q;
  logic [BW-1:0]     b_next;
  logic              div_wrap;
  logic              fall_evt;
  logic              rise_evt;

  logic [DWIDTH-1:0] fifo_mem [FIFODEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_count;
  logic              pop;
  logic              push;
  logic [DWIDTH-1:0] next_word;

  logic [DWIDTH-1:0] tx_word;
  logic [DWIDTH-1:0] tx_shift;
  logic [DWIDTH-1:0] rx_shift;
  logic              rx_done;

  assign div_wrap = (div_q == DIV_LAST);
  assign fall_evt = div_wrap & bclk;
  assign rise_evt = div_wrap & ~bclk;

  // output_valid and input_ready are single-cycle strobes with no back-pressure:
  // each high clock is one write attempt / one consume attempt, taken or dropped.
  always_comb begin
    b_next    = b_q;
    pop       = 1'b0;
    push      = 1'b0;
    next_word = tx_word;
    if (fall_evt) b_next = (b_q == B_LAST) ? '0 : b_q + B_ONE;
    if (fall_evt && (b_next == B_ONE) && (fifo_count != '0)) begin
      pop       = 1'b1;
      next_word = fifo_mem[rd_ptr];
    end
    // A pop in the same clock frees the slot the write needs.
    push = output_valid && ((fifo_count != CNT_FULL) || pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      bclk  <= 1'b0;
      b_q   <= '0;
      lrclk <= 1'b0;
    end else begin
      div_q <= div_wrap ? '0 : div_q + DIVW'(1);
      if (div_wrap) bclk <= ~bclk;
      if (fall_evt) begin
        b_q   <= b_next;
        lrclk <= (b_next >= B_DW);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= outport;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (output_valid && !push) tx_overflow <= 1'b1;
    end
  end

  // Each slot reloads the word and shifts MSB first; the right slot's LSB lands on b=0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_word   <= '0;
      tx_shift  <= '0;
      dac_sdata <= 1'b0;
    end else if (fall_evt) begin
      if (b_next == B_ONE) begin
        tx_word   <= next_word;
        dac_sdata <= next_word[DWIDTH-1];
        tx_shift  <= next_word << 1;
      end else if (b_next == B_RSTART) begin
        dac_sdata <= tx_word[DWIDTH-1];
        tx_shift  <= tx_word << 1;
      end else begin
        dac_sdata <= tx_shift[DWIDTH-1];
        tx_shift  <= tx_shift << 1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_shift   <= '0;
      rx_done    <= 1'b0;
      adcdata    <= '0;
      adc_valid  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (rise_evt && (b_q >= B_ONE) && (b_q <= B_DW)) begin
        rx_shift <= {rx_shift[DWIDTH-2:0], adc_sdata};
        rx_done  <= (b_q == B_DW);
      end
      if (rx_done) begin
        adcdata   <= rx_shift;
        adc_valid <= 1'b1;
        if (adc_valid && !input_ready) rx_overrun <= 1'b1;
      end else if (input_ready && adc_valid) begin
        adc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_bridge.sv
// Directed bench for audio_i2s_bridge: clock timing, TX FIFO/serialiser, RX capture,
// overrun/overflow flags and mid-frame reset, all against hand-derived frame positions.
module tb_audio_i2s_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] outport = '0;
  logic        output_valid = 1'b0;
  logic        input_ready = 1'b0;
  logic [31:0] adcdata;
  logic        adc_valid;
  logic        tx_overflow;
  logic        rx_overrun;
  logic        bclk;
  logic        lrclk;
  logic        dac_sdata;
  logic        adc_sdata = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] adc_l [8];
  logic [31:0] adc_r = 32'hFFFF_FFFF;
  logic [31:0] exp_w [8];
  int          ab;
  int          af;
  logic        eb;

  audio_i2s_bridge #(.DWIDTH(32), .BCLKDIV(2), .FIFODEPTH(4)) dut (
    .clock(clock), .reset(reset), .outport(outport), .output_valid(output_valid),
    .input_ready(input_ready), .adcdata(adcdata), .adc_valid(adc_valid),
    .tx_overflow(tx_overflow), .rx_overrun(rx_overrun), .bclk(bclk), .lrclk(lrclk),
    .dac_sdata(dac_sdata), .adc_sdata(adc_sdata)
  );

  // clock / reset-relative cycle counter (cyc = posedges since reset release)
  always #5 clock = ~clock;

  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: run exceeded time limit, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic word_bit(input logic [31:0] w, input int i);
    logic [31:0] t;
    t = w >> i;
    return t[0];
  endfunction

  // Expected DAC bit at bit index b for a transmitted word (MSB first, 1-bit delay).
  function automatic logic exp_dac(input logic [31:0] w, input int b);
    if (b == 0)       return word_bit(w, 0);
    else if (b <= 32) return word_bit(w, 32 - b);
    else              return word_bit(w, 64 - b);
  endfunction

  // ADC model: drives the bit for the current slot position just after each clock.
  always @(posedge clock) begin
    #1;
    ab = (cyc / 4) % 64;
    af = (cyc / 256) % 8;
    if (ab >= 1 && ab <= 32) adc_sdata = word_bit(adc_l[af[2:0]], 32 - ab);
    else                     adc_sdata = word_bit(adc_r, (ab == 0) ? 0 : 64 - ab);
  end

  // driver tasks
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    output_valid = 1'b0;
    input_ready = 1'b0;
    outport = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic clear_adc();
    for (int i = 0; i < 8; i++) adc_l[i] = '0;
  endtask

  task automatic test_reset();
    clear_adc();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (bclk !== 1'b0)       begin errors++; $display("FAIL rst_bclk got %b exp 0", bclk); end
    checks++; if (lrclk !== 1'b0)      begin errors++; $display("FAIL rst_lrclk got %b exp 0", lrclk); end
    checks++; if (dac_sdata !== 1'b0)  begin errors++; $display("FAIL rst_dac got %b exp 0", dac_sdata); end
    checks++; if (adcdata !== 32'h0)   begin errors++; $display("FAIL rst_adcdata got %h exp 0", adcdata); end
    checks++; if (adc_valid !== 1'b0)  begin errors++; $display("FAIL rst_adc_valid got %b exp 0", adc_valid); end
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL rst_tx_overflow got %b exp 0", tx_overflow); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL rst_rx_overrun got %b exp 0", rx_overrun); end
    @(posedge clock);
    #1 reset = 1'b1;
    for (int c = 1; c <= 258; c++) begin
      goto(c);
      @(negedge clock);
      checks++;
      if (bclk !== 1'((c / 2) % 2)) begin
        errors++; $display("FAIL clk_bclk cyc %0d got %b exp %b", c, bclk, 1'((c / 2) % 2));
      end
      checks++;
      if (lrclk !== (((c / 4) % 64) >= 32)) begin
        errors++; $display("FAIL clk_lrclk cyc %0d got %b exp %b", c, lrclk, ((c / 4) % 64) >= 32);
      end
    end
  endtask

  task automatic test_single_word();
    do_reset();
    goto(1);
    outport = 32'hA5A5_0001;
    output_valid = 1'b1;
    goto(2);
    output_valid = 1'b0;
    for (int c = 4; c <= 3 * 256 + 3; c++) begin
      if (c % 4 == 2) begin
        goto(c);
        @(negedge clock);
        eb = exp_dac(32'hA5A5_0001, (c / 4) % 64);
        checks++;
        if (dac_sdata !== eb) begin
          errors++; $display("FAIL single_dac cyc %0d b %0d got %b exp %b", c, (c / 4) % 64, dac_sdata, eb);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    output_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      goto(9 + i);
      outport = 32'(i);
      output_valid = 1'b1;
    end
    goto(14);
    @(negedge clock);
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL b2b_no_ovf got %b exp 0", tx_overflow); end
    outport = 32'h5;
    goto(15);
    output_valid = 1'b0;
    @(negedge clock);
    checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL b2b_ovf got %b exp 1", tx_overflow); end
    exp_w[1] = 32'h1; exp_w[2] = 32'h2; exp_w[3] = 32'h3;
    exp_w[4] = 32'h4; exp_w[5] = 32'h4; exp_w[6] = 32'h4;
    for (int f = 1; f <= 6; f++) begin
      for (int c = f * 256 + 4; c <= f * 256 + 259; c++) begin
        if (c % 4 == 2) begin
          goto(c);
          @(negedge clock);
          eb = exp_dac(exp_w[f], (c / 4) % 64);
          checks++;
          if (dac_sdata !== eb) begin
            errors++; $display("FAIL b2b_dac frame %0d b %0d got %b exp %b", f, (c / 4) % 64, dac_sdata, eb);
          end
        end
      end
    end
    checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL b2b_ovf_sticky got %b exp 1", tx_overflow); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      goto(9 + i);
      outport = 32'(i);
      output_valid = 1'b1;
    end
    goto(14);
    output_valid = 1'b0;
    goto(259);
    outport = 32'h6;
    output_valid = 1'b1;
    goto(260);
    output_valid = 1'b0;
    @(negedge clock);
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %b exp 0", tx_overflow); end
    exp_w[1] = 32'h1; exp_w[2] = 32'h2; exp_w[3] = 32'h3; exp_w[4] = 32'h4; exp_w[5] = 32'h6;
    for (int f = 1; f <= 5; f++) begin
      for (int c = f * 256 + 4; c <= f * 256 + 259; c++) begin
        if (c % 4 == 2) begin
          goto(c);
          @(negedge clock);
          eb = exp_dac(exp_w[f], (c / 4) % 64);
          checks++;
          if (dac_sdata !== eb) begin
            errors++; $display("FAIL fullpop_dac frame %0d b %0d got %b exp %b", f, (c / 4) % 64, dac_sdata, eb);
          end
        end
      end
    end
  endtask

  task automatic test_rx_consume();
    clear_adc();
    adc_l[0] = 32'h8000_0003;
    do_reset();
    goto(130);
    @(negedge clock);
    checks++; if (adc_valid !== 1'b0) begin errors++; $display("FAIL rx_early_valid got %b exp 0", adc_valid); end
    goto(131);
    @(negedge clock);
    checks++; if (adc_valid !== 1'b1) begin errors++; $display("FAIL rx_valid got %b exp 1", adc_valid); end
    checks++; if (adcdata !== 32'h8000_0003) begin errors++; $display("FAIL rx_data got %h exp 80000003", adcdata); end
    goto(140);
    input_ready = 1'b1;
    goto(141);
    input_ready = 1'b0;
    @(negedge clock);
    checks++; if (adc_valid !== 1'b0) begin errors++; $display("FAIL rx_consume_valid got %b exp 0", adc_valid); end
    checks++; if (adcdata !== 32'h8000_0003) begin errors++; $display("FAIL rx_consume_data got %h exp 80000003", adcdata); end
    goto(250);
    @(negedge clock);
    checks++; if (adcdata !== 32'h8000_0003) begin errors++; $display("FAIL rx_right_ignored got %h exp 80000003", adcdata); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL rx_no_overrun got %b exp 0", rx_overrun); end
  endtask

  task automatic test_rx_overrun();
    clear_adc();
    adc_l[0] = 32'h1111_1111;
    adc_l[1] = 32'h2222_2222;
    do_reset();
    goto(131);
    @(negedge clock);
    checks++; if (adcdata !== 32'h1111_1111) begin errors++; $display("FAIL ovr_first got %h exp 11111111", adcdata); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_flag got %b exp 0", rx_overrun); end
    goto(387);
    @(negedge clock);
    checks++; if (adcdata !== 32'h2222_2222) begin errors++; $display("FAIL ovr_second got %h exp 22222222", adcdata); end
    checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", rx_overrun); end
    do_reset();
    goto(386);
    input_ready = 1'b1;
    goto(387);
    input_ready = 1'b0;
    @(negedge clock);
    checks++; if (adcdata !== 32'h2222_2222) begin errors++; $display("FAIL ovr_coincide_data got %h exp 22222222", adcdata); end
    checks++; if (adc_valid !== 1'b1) begin errors++; $display("FAIL ovr_coincide_valid got %b exp 1", adc_valid); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_coincide_flag got %b exp 0", rx_overrun); end
  endtask

  task automatic test_reset_mid_frame();
    clear_adc();
    adc_l[0] = 32'h0000_ABCD;
    do_reset();
    goto(10);
    outport = 32'h77;
    output_valid = 1'b1;
    goto(11);
    output_valid = 1'b0;
    goto(300);
    outport = 32'h88;
    output_valid = 1'b1;
    goto(301);
    outport = 32'h99;
    goto(302);
    output_valid = 1'b0;
    goto(325);
    checks++; if (adc_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", adc_valid); end
    reset = 1'b0;
    #1;
    checks++; if (bclk !== 1'b0)       begin errors++; $display("FAIL mid_bclk got %b exp 0", bclk); end
    checks++; if (lrclk !== 1'b0)      begin errors++; $display("FAIL mid_lrclk got %b exp 0", lrclk); end
    checks++; if (dac_sdata !== 1'b0)  begin errors++; $display("FAIL mid_dac got %b exp 0", dac_sdata); end
    checks++; if (adcdata !== 32'h0)   begin errors++; $display("FAIL mid_adcdata got %h exp 0", adcdata); end
    checks++; if (adc_valid !== 1'b0)  begin errors++; $display("FAIL mid_adc_valid got %b exp 0", adc_valid); end
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL mid_tx_overflow got %b exp 0", tx_overflow); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL mid_rx_overrun got %b exp 0", rx_overrun); end
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    for (int c = 2; c <= 600; c += 2) begin
      goto(c);
      @(negedge clock);
      checks++;
      if (bclk !== 1'((c / 2) % 2)) begin
        errors++; $display("FAIL mid_re_bclk cyc %0d got %b exp %b", c, bclk, 1'((c / 2) % 2));
      end
      checks++;
      if (lrclk !== (((c / 4) % 64) >= 32)) begin
        errors++; $display("FAIL mid_re_lrclk cyc %0d got %b exp %b", c, lrclk, ((c / 4) % 64) >= 32);
      end
      checks++;
      if (dac_sdata !== 1'b0) begin
        errors++; $display("FAIL mid_fifo_empty cyc %0d dac got %b exp 0", c, dac_sdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_full_pop();
    test_rx_consume();
    test_rx_overrun();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
